gf2_matvec_seq: RTL and testbench

Sequential controller for GF(2) matrix–vector multiplication that computes u = M^k·v for an N×N binary matrix. Multiplication is AND and addition is XOR. The block owns a register file holding M, accepts a vector and an iteration count over a valid/ready handshake, and sequences one shared row dot-product unit across all N rows for k passes. The result is returned over a second valid/ready handshake. It sits between a host/config path that loads M and the consumers of transformed vectors (scramblers, LFSR-style state advance).

---
 rtl/gf2_pkg.sv | 15 +
 rtl/gf2_dot.sv | 12 +
 rtl/gf2_matvec_seq.sv | 152 +++++++++++++++
 tb/tb_gf2_matvec_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_pkg.sv
// rtl/gf2_pkg.sv - shared types and helpers for the GF(2) matrix-vector sequencer
package gf2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Row-index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gf2_dot.sv
// rtl/gf2_dot.sv - combinational GF(2) dot product of one matrix row with a vector
module gf2_dot #(
  parameter int N = 4
) (
  input  logic [N-1:0] row,
  input  logic [N-1:0] vec,
  output logic         bit_out
);

  assign bit_out = ^(row & vec);

endmodule

// File: rtl/gf2_matvec_seq.sv
// rtl/gf2_matvec_seq.sv - computes M^k * v over GF(2) using one shared row dot-product unit
module gf2_matvec_seq
  import gf2_pkg::*;
#(
  parameter int N   = 4,
  parameter int K_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 row_we,
  input  logic [$clog2(N)-1:0] row_addr,
  input  logic [N-1:0]         row_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  input  logic [K_W-1:0]       in_iter,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_vec,
  output logic                 busy
);

  localparam int RW = idx_w(N);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   mat [N];
  logic [N-1:0]   w;
  logic [N-1:0]   nxt;
  logic [N-1:0]   nxt_full;
  logic [N-1:0]   out_vec_q;
  logic [RW-1:0]  r;
  logic [K_W-1:0] k;
  logic           out_valid_q;
  logic           dot_bit;
  logic           accept;
  logic           last_row;
  logic           last_pass;

  assign accept    = in_valid & in_ready;
  assign last_row  = (r == LAST_ROW);
  assign last_pass = (k == K_W'(1));

  gf2_dot #(.N(N)) u_dot (
    .row     (mat[r]),
    .vec     (w),
    .bit_out (dot_bit)
  );

  // Accumulator including the bit produced this cycle, so the last row can write back directly.
  always_comb begin
    nxt_full    = nxt;
    nxt_full[r] = dot_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (in_iter == '0) ? ST_DONE : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (last_row && last_pass) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_IDLE);
    busy     = (state == ST_COMPUTE) || (state == ST_DONE);
  end

  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;

  // Matrix writes are only taken in IDLE so M is frozen for the duration of a job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mat[i] <= '0;
      end
    end else if (row_we && in_ready) begin
      for (int i = 0; i < N; i++) begin
        if (row_addr == RW'(i)) begin
          mat[i] <= row_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w           <= '0;
      nxt         <= '0;
      r           <= '0;
      k           <= '0;
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            w <= in_vec;
            k <= in_iter;
            r <= '0;
            if (in_iter == '0) begin
              out_vec_q <= in_vec;
            end
          end
        end
        ST_COMPUTE: begin
          nxt <= nxt_full;
          if (last_row) begin
            w <= nxt_full;
            r <= '0;
            if (k != '0) begin
              k <= k - K_W'(1);
            end
            if (last_pass) begin
              out_vec_q <= nxt_full;
            end
          end else begin
            r <= r + RW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_matvec_seq.sv
// tb/tb_gf2_matvec_seq.sv - randomized self-checking bench for gf2_matvec_seq against a matrix-power model
module tb_gf2_matvec_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       row_we = 1'b0;
  logic [1:0] row_addr = '0;
  logic [3:0] row_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_vec = '0;
  logic [7:0] in_iter = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_vec;
  logic       busy;

  logic [3:0] mref [4];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gf2_matvec_seq #(.N(4), .K_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_we    (row_we),
    .row_addr  (row_addr),
    .row_data  (row_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .in_iter   (in_iter),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  // u = M^k v: each pass, output bit r is the parity of (row r AND current vector).
  function automatic logic [3:0] ref_pow(input logic [3:0] v, input int k);
    logic [3:0] cur, nv;
    cur = v;
    for (int p = 0; p < k; p++) begin
      for (int rr = 0; rr < 4; rr++) begin
        nv[rr] = ($countones(mref[rr] & cur) % 2) == 1;
      end
      cur = nv;
    end
    return cur;
  endfunction

  task automatic set_row(input int rr, input logic [3:0] d);
    @(negedge clk);
    row_we = 1'b1; row_addr = 2'(rr); row_data = d;
    @(negedge clk);
    row_we = 1'b0;
    mref[rr] = d;
  endtask

  task automatic run_job(input string name, input logic [3:0] v, input int k,
                         input logic wr, input int wr_addr, input logic [3:0] wr_data);
    logic [3:0] exp_vec;
    int lat, exp_lat;
    @(negedge clk);
    if (wr) begin
      row_we = 1'b1; row_addr = 2'(wr_addr); row_data = wr_data;
      mref[wr_addr] = wr_data;
    end
    exp_vec = ref_pow(v, k);
    exp_lat = (k == 0) ? 1 : k * 4 + 1;
    in_valid = 1'b1; in_vec = v; in_iter = 8'(k);
    @(posedge clk); #1;
    in_valid = 1'b0; row_we = 1'b0;
    lat = 1;
    while (!out_valid && lat < 2200) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_vec !== exp_vec) begin
      errors++; $display("FAIL %s out_vec: got %b required %b", name, out_vec, exp_vec);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s handshake: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) mref[i] = '0;
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset: out_valid=%b in_ready=%b busy=%b out_vec=%b required 0/1/0/0000",
               out_valid, in_ready, busy, out_vec);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_identity();
    for (int i = 0; i < 4; i++) set_row(i, 4'(1 << i));
    run_job("identity_k3", 4'b1011, 3, 1'b0, 0, '0);
  endtask

  task automatic test_rotate();
    for (int i = 0; i < 4; i++) set_row(i, 4'(1 << ((i + 1) % 4)));
    run_job("rotate_k1", 4'b0001, 1, 1'b0, 0, '0);
    run_job("rotate_k5", 4'b0001, 5, 1'b0, 0, '0);
    run_job("rotate_k4", 4'b0001, 4, 1'b0, 0, '0);
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < 4; i++) set_row(i, 4'b1111);
    run_job("ones_k1", 4'b0111, 1, 1'b0, 0, '0);
    run_job("ones_k2", 4'b0111, 2, 1'b0, 0, '0);
  endtask

  task automatic test_k_zero();
    run_job("k_zero", 4'b1010, 0, 1'b0, 0, '0);
  endtask

  task automatic test_same_edge_write();
    for (int i = 0; i < 4; i++) set_row(i, 4'(1 << i));
    run_job("same_edge_wr", 4'b0110, 1, 1'b1, 2, 4'b1111);
  endtask

  task automatic test_backpressure();
    logic [3:0] v;
    int lat;
    for (int i = 0; i < 4; i++) set_row(i, 4'(1 << i));
    v = 4'($urandom_range(15));
    @(negedge clk);
    in_valid = 1'b1; in_vec = v; in_iter = 8'd2;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      row_we = (i == 2); in_valid = (i == 2);
      row_addr = 2'd0; row_data = 4'b1111; in_vec = ~v; in_iter = 8'd0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_vec !== v || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL backpressure cycle %0d: out_valid=%b out_vec=%b in_ready=%b busy=%b required 1/%b/0/1",
                 i, out_valid, out_vec, in_ready, busy, v);
      end
    end
    @(negedge clk); row_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    run_job("bp_followup", 4'($urandom_range(15)), 1, 1'b0, 0, '0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 4; i++) set_row(i, 4'($urandom_range(15)));
      run_job("random", 4'($urandom_range(15)), int'($urandom_range(20)), 1'b0, 0, '0);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] v, exp_vec;
    int cyc, prev, pulses;
    for (int i = 0; i < 4; i++) set_row(i, 4'($urandom_range(15)));
    v = 4'($urandom_range(15));
    exp_vec = ref_pow(v, 2);
    @(negedge clk);
    in_valid = 1'b1; in_vec = v; in_iter = 8'd2; out_ready = 1'b1;
    cyc = 0; prev = -1; pulses = 0;
    while (pulses < 3 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      if (out_valid) begin
        checks++;
        if (out_vec !== exp_vec) begin
          errors++; $display("FAIL b2b out_vec: got %b required %b", out_vec, exp_vec);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev !== 10) begin
            errors++; $display("FAIL b2b period: got %0d required 10", cyc - prev);
          end
        end
        prev = cyc; pulses++;
      end
    end
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (pulses !== 3) begin
      errors++; $display("FAIL b2b timeout: pulses=%0d required 3", pulses);
    end
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) set_row(i, 4'b1111);
    @(negedge clk);
    in_valid = 1'b1; in_vec = 4'b0111; in_iter = 8'd5;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) mref[i] = '0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_vec !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b busy=%b out_vec=%b required 0/1/0/0000",
               out_valid, in_ready, busy, out_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    run_job("post_reset", 4'($urandom_range(1, 15)), 1, 1'b0, 0, '0);
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate();
    test_all_ones();
    test_k_zero();
    test_same_edge_write();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
